// File: rtl/add16_arbiter.sv
// Round-robin scheduler that shares one external 16-bit adder among NUM_REQ requesters.
// One operation in flight at a time: IDLE (grant) -> ADD (adder settles) -> RESP (hold result).
module add16_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [15:0]           adder_a,
  output logic [15:0]           adder_b,
  input  logic [15:0]           adder_out,
  output logic                  rsp_valid,
  output logic [15:0]           rsp_data,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  rsp_ready,
  output logic [15:0]           op_count
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] grant_idx;
  logic           found;

  // Scan starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found     = 1'b1;
        grant_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Grant is held off while reset is asserted so req_ready reads zero during reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && rst_n && found)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NUM_REQ - 1);
      id_q      <= '0;
      adder_a   <= '0;
      adder_b   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            adder_a <= req_a[int'(grant_idx)*16 +: 16];
            adder_b <= req_b[int'(grant_idx)*16 +: 16];
            id_q    <= grant_idx;
            rr_ptr  <= grant_idx;
            state   <= ADD;
          end
        end
        ADD: begin
          rsp_data  <= adder_out;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add16_arbiter.sv
// Directed bench for add16_arbiter: vector table for single ops, then hand-written
// backpressure, mid-op reset and round-robin fairness sequences.
module tb_add16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  req_ready;
  logic [15:0] adder_a, adder_b, adder_out;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready = 1'b0;
  logic [15:0] op_count;

  add16_arbiter #(.NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .adder_a(adder_a), .adder_b(adder_b), .adder_out(adder_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .op_count(op_count)
  );

  always #5 clk = ~clk;
  assign adder_out = adder_a + adder_b;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          id;
    logic [15:0] sum;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 10) begin
      tick();
      t++;
    end
    chk("rsp_wait", {31'b0, rsp_valid}, 32'd1);
  endtask

  initial begin
    vec_t        vecs[6];
    logic [15:0] exp_cnt;
    logic [15:0] fa[4];
    logic [15:0] fb[4];
    logic [15:0] s;

    vecs[0] = '{16'h1234, 16'h9876, 0, 16'hAAAA};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1, 16'hFFFE};
    vecs[2] = '{16'hFFFF, 16'h0001, 2, 16'h0000};
    vecs[3] = '{16'h0000, 16'h0000, 3, 16'h0000};
    vecs[4] = '{16'h8000, 16'h8000, 1, 16'h0000};
    vecs[5] = '{16'h0F0F, 16'hF0F0, 3, 16'hFFFF};

    // reset values
    #2;
    chk("rst_ready", {28'b0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", {16'b0, rsp_data}, 32'h0);
    chk("rst_rsp_id", {30'b0, rsp_id}, 32'h0);
    chk("rst_adder_a", {16'b0, adder_a}, 32'h0);
    chk("rst_adder_b", {16'b0, adder_b}, 32'h0);
    chk("rst_op_count", {16'b0, op_count}, 32'h0);
    #20 rst_n = 1'b1;
    tick();

    // single-requester vectors
    exp_cnt = 16'd0;
    rsp_ready = 1'b1;
    foreach (vecs[i]) begin
      req_a[16*vecs[i].id +: 16] = vecs[i].a;
      req_b[16*vecs[i].id +: 16] = vecs[i].b;
      req_valid = 4'(1) << vecs[i].id;
      #1;
      chk("vec_grant", {28'b0, req_ready}, {28'b0, 4'(1) << vecs[i].id});
      tick();
      req_valid = '0;
      chk("vec_add_ready", {28'b0, req_ready}, 32'h0);
      chk("vec_add_valid", {31'b0, rsp_valid}, 32'h0);
      chk("vec_adder_a", {16'b0, adder_a}, {16'b0, vecs[i].a});
      chk("vec_adder_b", {16'b0, adder_b}, {16'b0, vecs[i].b});
      tick();
      chk("vec_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("vec_rsp_data", {16'b0, rsp_data}, {16'b0, vecs[i].sum});
      chk("vec_rsp_id", {30'b0, rsp_id}, 32'(vecs[i].id));
      tick();
      exp_cnt++;
      chk("vec_op_count", {16'b0, op_count}, {16'b0, exp_cnt});
      chk("vec_rsp_drop", {31'b0, rsp_valid}, 32'h0);
      chk("vec_adder_hold", {16'b0, adder_a}, {16'b0, vecs[i].a});
    end

    // backpressure: req0 and req1 both valid, last winner was 3 so 0 goes first
    rsp_ready = 1'b0;
    req_a[15:0] = 16'h0100; req_b[15:0] = 16'h0001;
    req_a[31:16] = 16'h0002; req_b[31:16] = 16'h0003;
    req_valid = 4'b0011;
    #1;
    chk("bp_grant0", {28'b0, req_ready}, 32'h1);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_data", {16'b0, rsp_data}, 32'h0101);
      chk("bp_id", {30'b0, rsp_id}, 32'h0);
      chk("bp_ready", {28'b0, req_ready}, 32'h0);
      chk("bp_count", {16'b0, op_count}, {16'b0, exp_cnt});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'h0);
    chk("bp_next_grant", {28'b0, req_ready}, 32'h2);
    chk("bp_count_inc", {16'b0, op_count}, {16'b0, exp_cnt});
    tick();
    req_valid = '0;
    tick();
    chk("bp_second_id", {30'b0, rsp_id}, 32'h1);
    chk("bp_second_data", {16'b0, rsp_data}, 32'h0005);
    tick();

    // reset while in ADD
    req_a[15:0] = 16'h0005; req_b[15:0] = 16'h0006;
    req_valid = 4'b0001;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {28'b0, req_ready}, 32'h0);
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("mid_rst_adder_a", {16'b0, adder_a}, 32'h0);
    chk("mid_rst_count", {16'b0, op_count}, 32'h0);
    req_valid = '0;
    #2 rst_n = 1'b1;
    req_a[47:32] = 16'h1111; req_b[47:32] = 16'h2222;
    req_valid = 4'b0100;
    wait_rsp();
    req_valid = '0;
    chk("mid_rst_id", {30'b0, rsp_id}, 32'h2);
    chk("mid_rst_data", {16'b0, rsp_data}, 32'h3333);
    tick();
    chk("mid_rst_count1", {16'b0, op_count}, 32'h1);

    // fairness: all four valid from reset
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fa[i] = 16'(16'h1000 * (i + 1) + i);
      fb[i] = 16'(16'h0101 * (i + 1));
      req_a[16*i +: 16] = fa[i];
      req_b[16*i +: 16] = fb[i];
    end
    req_valid = 4'b1111;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_rsp();
      s = fa[k % 4] + fb[k % 4];
      chk("rr_id", {30'b0, rsp_id}, 32'(k % 4));
      chk("rr_data", {16'b0, rsp_data}, {16'b0, s});
      tick();
    end
    chk("rr_count", {16'b0, op_count}, 32'h6);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
